// File: rtl/nic_defs_pkg.sv
// Definitions shared by the CCI-P TX/RX flow schedulers: batch sizing, CL length
// encoding and the scheduler state type.
package nic_defs_pkg;

  localparam int LMAX_CCIP_BATCH = 2;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [1:0] {
    TxSchedIdle,
    TxSchedPop,
    TxSchedGap
  } tx_sched_state_e;

  typedef struct packed {
    logic [2:0]  size;
    t_ccip_clLen cl_len;
  } batch_cfg_t;

  // Anything above 4 CLs is clamped, since a CCI-P request tops out at 4 lines.
  function automatic batch_cfg_t batch_decode(input logic [LMAX_CCIP_BATCH-1:0] l_batch);
    batch_cfg_t cfg;
    case (l_batch)
      2'd0: begin
        cfg.size   = 3'd1;
        cfg.cl_len = eCL_LEN_1;
      end
      2'd1: begin
        cfg.size   = 3'd2;
        cfg.cl_len = eCL_LEN_2;
      end
      default: begin
        cfg.size   = 3'd4;
        cfg.cl_len = eCL_LEN_4;
      end
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester above the last grant, else the
// lowest requester; requesters above the limit index are ignored.
module rr_priority_picker #(
  parameter int LN = 1
) (
  input  logic [(2**LN)-1:0] req_i,
  input  logic [LN-1:0]      last_i,
  input  logic [LN-1:0]      limit_i,
  output logic [LN-1:0]      grant_o,
  output logic               valid_o
);

  localparam int N = 2**LN;

  logic [LN-1:0] hi_idx;
  logic [LN-1:0] lo_idx;
  logic          hi_vld;
  logic          lo_vld;

  // Scanning downwards leaves the lowest matching index in each candidate.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (LN'(i) <= limit_i)) begin
        lo_idx = LN'(i);
        lo_vld = 1'b1;
        if (LN'(i) > last_i) begin
          hi_idx = LN'(i);
          hi_vld = 1'b1;
        end
      end
    end
  end

  assign grant_o = hi_vld ? hi_idx : lo_idx;
  assign valid_o = lo_vld;

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// CCI-P TX batch scheduler: grants whole batches round-robin across flow FIFOs and
// sequences their pop strobes, stalling on C1 almost-full.
//
// state       | meaning
// TxSchedIdle | waiting for start and an eligible flow; grant edge also issues beat 0
// TxSchedPop  | issuing the remaining beats of the granted batch
// TxSchedGap  | letting FIFO fill levels settle before the next scan
module ccip_tx_flow_scheduler
  import nic_defs_pkg::*;
#(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFIFO_DEPTH       = 3,
  parameter int GAP_CYCLES        = 2
) (
  input  logic                                                   clk,
  input  logic                                                   resetn,
  input  logic                                                   start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                           number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]                             l_tx_batch_size,
  input  logic                                                   sRx_c1TxAlmFull,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*(LFIFO_DEPTH+1)-1:0]      ff_dw_in,
  output logic [(2**LMAX_NUM_OF_FLOWS)-1:0]                      pop_en_out,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                           pop_flow_id_out,
  output logic                                                   pop_sop_out,
  output logic                                                   pop_eop_out,
  output logic [1:0]                                             cl_len_out,
  output logic                                                   busy_out,
  output logic [31:0]                                            batches_out
);

  localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int FW        = LFIFO_DEPTH + 1;
  localparam int GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  tx_sched_state_e state_q, state_d;
  logic [LMAX_NUM_OF_FLOWS-1:0] flow_q, flow_d, last_grant_q, last_grant_d;
  logic [2:0]                   size_q, size_d, beat_q, beat_d;
  t_ccip_clLen                  cl_q, cl_d;
  logic [GW-1:0]                gap_q, gap_d;
  logic [31:0]                  batches_q, batches_d;

  logic [MAX_FLOWS-1:0]         pop_en_q, pop_en_d;
  logic [LMAX_NUM_OF_FLOWS-1:0] flow_id_q, flow_id_d;
  logic                         sop_q, sop_d, eop_q, eop_d, busy_q, busy_d;
  logic [1:0]                   cl_len_q, cl_len_d;

  batch_cfg_t                   cfg;
  logic [MAX_FLOWS-1:0]         eligible;
  logic [LMAX_NUM_OF_FLOWS-1:0] pick_flow, cur_flow;
  logic                         pick_valid, issue;
  logic [2:0]                   cur_size, cur_beat;
  t_ccip_clLen                  cur_cl;

  assign cfg = batch_decode(l_tx_batch_size);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < MAX_FLOWS; i++) begin
      eligible[i] = ff_dw_in[i*FW +: FW] >= FW'(cfg.size);
    end
  end

  rr_priority_picker #(
    .LN(LMAX_NUM_OF_FLOWS)
  ) u_picker (
    .req_i  (eligible),
    .last_i (last_grant_q),
    .limit_i(number_of_flows),
    .grant_o(pick_flow),
    .valid_o(pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    flow_d       = flow_q;
    size_d       = size_q;
    cl_d         = cl_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    batches_d    = batches_q;
    pop_en_d     = '0;
    flow_id_d    = flow_id_q;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    cl_len_d     = cl_len_q;
    cur_flow     = flow_q;
    cur_size     = size_q;
    cur_cl       = cl_q;
    cur_beat     = beat_q;
    issue        = 1'b0;

    // Configuration is only looked at here; a running batch uses its latched copy.
    case (state_q)
      TxSchedIdle: begin
        cur_flow = pick_flow;
        cur_size = cfg.size;
        cur_cl   = cfg.cl_len;
        cur_beat = '0;
        issue    = start && !sRx_c1TxAlmFull && pick_valid;
      end
      TxSchedPop: issue = !sRx_c1TxAlmFull;
      TxSchedGap: begin
        if (gap_q == '0) state_d = TxSchedIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = TxSchedIdle;
    endcase

    if (issue) begin
      pop_en_d  = MAX_FLOWS'(1) << cur_flow;
      flow_id_d = cur_flow;
      cl_len_d  = cur_cl;
      sop_d     = (cur_beat == 3'd0);
      eop_d     = (cur_beat == cur_size - 3'd1);
      flow_d    = cur_flow;
      size_d    = cur_size;
      cl_d      = cur_cl;
      if (eop_d) begin
        last_grant_d = cur_flow;
        batches_d    = batches_q + 32'd1;
        gap_d        = GAP_LOAD;
        state_d      = TxSchedGap;
      end else begin
        beat_d  = cur_beat + 3'd1;
        state_d = TxSchedPop;
      end
    end
  end

  assign busy_d = (state_d != TxSchedIdle);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= TxSchedIdle;
      flow_q       <= '0;
      size_q       <= '0;
      cl_q         <= eCL_LEN_1;
      beat_q       <= '0;
      gap_q        <= '0;
      last_grant_q <= LMAX_NUM_OF_FLOWS'(MAX_FLOWS - 1);
      batches_q    <= '0;
      pop_en_q     <= '0;
      flow_id_q    <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      cl_len_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flow_q       <= flow_d;
      size_q       <= size_d;
      cl_q         <= cl_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      last_grant_q <= last_grant_d;
      batches_q    <= batches_d;
      pop_en_q     <= pop_en_d;
      flow_id_q    <= flow_id_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      cl_len_q     <= cl_len_d;
      busy_q       <= busy_d;
    end
  end

  assign pop_en_out      = pop_en_q;
  assign pop_flow_id_out = flow_id_q;
  assign pop_sop_out     = sop_q;
  assign pop_eop_out     = eop_q;
  assign cl_len_out      = cl_len_q;
  assign busy_out        = busy_q;
  assign batches_out     = batches_q;

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Bench for ccip_tx_flow_scheduler: batch-level behavioural model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_ccip_tx_flow_scheduler;
  import nic_defs_pkg::*;

  localparam int LNF = 2;
  localparam int NF  = 4;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        resetn, start, alm;
  logic [1:0]  nf;
  logic [LMAX_CCIP_BATCH-1:0] lbs;
  logic [15:0] ff;
  logic [3:0]  pop_en;
  logic [1:0]  flow_id;
  logic        sop, eop, busy;
  logic [1:0]  cl_len;
  logic [31:0] batches;

  ccip_tx_flow_scheduler #(
    .LMAX_NUM_OF_FLOWS(LNF),
    .LFIFO_DEPTH      (3),
    .GAP_CYCLES       (GAP)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .number_of_flows(nf),
    .l_tx_batch_size(lbs),
    .sRx_c1TxAlmFull(alm),
    .ff_dw_in       (ff),
    .pop_en_out     (pop_en),
    .pop_flow_id_out(flow_id),
    .pop_sop_out    (sop),
    .pop_eop_out    (eop),
    .cl_len_out     (cl_len),
    .busy_out       (busy),
    .batches_out    (batches)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a granted batch is a count of beats left to send; after the
  // last beat the scheduler rests GAP cycles, then looks for the next flow in turn.
  logic [3:0]  e_pop;
  logic [1:0]  e_id, e_cl;
  logic        e_sop, e_eop, e_busy;
  logic [31:0] e_bat;
  int m_last, m_flow, m_beats, m_idx, m_gap, m_cl, sz, w;

  function automatic int pick(input int last, input int nflows, input logic [15:0] lv,
                              input int size);
    int n = nflows + 1;
    for (int k = 1; k <= n; k++) begin
      int idx = (last + k) % n;
      if (int'(lv[idx*4 +: 4]) >= size) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      e_pop = '0; e_id = '0; e_cl = '0; e_sop = 0; e_eop = 0; e_busy = 0; e_bat = '0;
      m_last = NF - 1; m_beats = 0; m_gap = 0; m_idx = 0; m_flow = 0; m_cl = 0;
    end else begin
      e_pop = '0; e_sop = 0; e_eop = 0;
      if (m_gap > 0) m_gap--;
      else begin
        if (m_beats == 0 && start && !alm) begin
          sz = (lbs == 0) ? 1 : (lbs == 1) ? 2 : 4;
          w  = pick(m_last, int'(nf), ff, sz);
          if (w >= 0) begin
            m_flow = w; m_beats = sz; m_idx = 0;
            m_cl = (sz == 1) ? 0 : (sz == 2) ? 1 : 3;
          end
        end
        if (m_beats > 0 && !alm) begin
          e_pop = 4'(1 << m_flow);
          e_id  = 2'(m_flow);
          e_cl  = 2'(m_cl);
          e_sop = (m_idx == 0);
          e_eop = (m_beats == 1);
          m_idx++;
          m_beats--;
          if (m_beats == 0) begin
            m_last = m_flow;
            e_bat  = e_bat + 1;
            m_gap  = GAP;
          end
        end
      end
      e_busy = (m_beats > 0) || (m_gap > 0);
    end
  end

  int strobes = 0;
  int cyc = 0;
  int sop_log[$];
  int pop_cyc[$];
  logic [3:0] pe_log[$];
  logic [1:0] se_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      check("pop_en", 32'(pop_en), 32'(e_pop));
      check("flow_id", 32'(flow_id), 32'(e_id));
      check("sop", 32'(sop), 32'(e_sop));
      check("eop", 32'(eop), 32'(e_eop));
      check("cl_len", 32'(cl_len), 32'(e_cl));
      check("busy", 32'(busy), 32'(e_busy));
      check("batches", batches, e_bat);
      if (pop_en != 0) begin
        strobes++;
        pop_cyc.push_back(cyc);
        pe_log.push_back(pop_en);
        se_log.push_back({sop, eop});
        if (sop) sop_log.push_back(int'(flow_id));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    strobes = 0;
    sop_log.delete();
    pop_cyc.delete();
    pe_log.delete();
    se_log.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    alm    = 1'b0;
    tick(2);
    resetn = 1'b1;
    clear_logs();
  endtask

  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    resetn = 1'b0; start = 1'b0; alm = 1'b0; nf = 2'd3; lbs = '0; ff = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // T1: only flow 1 holds a batch of 2
    do_reset();
    check("t1_reset_pop_en", 32'(pop_en), 32'h0);
    check("t1_reset_batches", batches, 32'd0);
    nf = 2'd3; lbs = 2'd1; ff = 16'h0020; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    check("t1_strobes", 32'(strobes), 32'd2);
    check("t1_pop0", 32'(pe_log[0]), 32'b0010);
    check("t1_pop1", 32'(pe_log[1]), 32'b0010);
    check("t1_sopeop0", 32'(se_log[0]), 32'b10);
    check("t1_sopeop1", 32'(se_log[1]), 32'b01);
    check("t1_cl_len", 32'(cl_len), 32'(eCL_LEN_2));
    check("t1_batches", batches, 32'd1);

    // T2: all four flows eligible, batch of 1, eight grants
    do_reset();
    nf = 2'd3; lbs = 2'd0; ff = 16'h4444; start = 1'b1;
    tick(22);
    start = 1'b0;
    tick(6);
    check("t2_grants", 32'(sop_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_order%0d", i), 32'(sop_log[i]), 32'(exp_order[i]));
    for (int i = 1; i < 8; i++) check($sformatf("t2_gap%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1] - 1), 32'(GAP));
    check("t2_batches", batches, 32'd8);

    // T3: batch of 4 on flow 2, almost-full for three cycles after the first beat
    do_reset();
    nf = 2'd3; lbs = 2'd2; ff = 16'h0400; start = 1'b1;
    tick(1);
    start = 1'b0; alm = 1'b1;
    tick(3);
    alm = 1'b0;
    tick(6);
    check("t3_strobes", 32'(strobes), 32'd4);
    check("t3_stall_span", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);
    check("t3_sops", 32'(sop_log.size()), 32'd1);
    check("t3_beat1_flags", 32'(se_log[1]), 32'b00);
    check("t3_beat3_flags", 32'(se_log[3]), 32'b01);
    check("t3_batches", batches, 32'd1);

    // T4: flow 3 is outside the active range until number_of_flows is raised
    do_reset();
    nf = 2'd1; lbs = 2'd1; ff = 16'h8000; start = 1'b1;
    tick(5);
    check("t4_no_grant", 32'(strobes), 32'd0);
    nf = 2'd3;
    tick(2);
    start = 1'b0;
    tick(4);
    check("t4_strobes", 32'(strobes), 32'd2);
    check("t4_flow", 32'(sop_log[0]), 32'd3);

    // T5: reset during the second beat of four
    do_reset();
    nf = 2'd3; lbs = 2'd2; ff = 16'h0004; start = 1'b1;
    tick(2);
    resetn = 1'b0;
    tick(1);
    check("t5_pop_en", 32'(pop_en), 32'h0);
    check("t5_batches", batches, 32'd0);
    check("t5_strobes", 32'(strobes), 32'd2);
    clear_logs();
    ff = 16'h4444; lbs = 2'd0; resetn = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("t5_regrant_cnt", 32'(sop_log.size()), 32'd1);
    check("t5_regrant_flow", 32'(sop_log[0]), 32'd0);

    // T6: start dropped after sop; clamped batch size (3 -> 4 CLs)
    do_reset();
    nf = 2'd3; lbs = 2'd3; ff = 16'h0080; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    check("t6_strobes", 32'(strobes), 32'd4);
    check("t6_sops", 32'(sop_log.size()), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_batches", batches, 32'd1);
    check("t6_cl_len", 32'(cl_len), 32'(eCL_LEN_4));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
